main_mem_responder: RTL and testbench

- Behavioural/synthesizable main-memory model: the responder end of the cache controller's main_read/main_write/ready interface.
- Accepts single-word writes (write-through and write-around traffic).
- Accepts block reads (refills) and returns a 4-word block.
- Signals completion of each operation with a one-cycle ready pulse after a fixed, parameterized latency.

---
 rtl/main_mem_responder.sv | 125 ++++++++++++
 tb/tb_main_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - main-memory responder: word writes, block refills, fixed-latency ready pulse
module main_mem_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  main_read,
    input  logic                                  main_write,
    input  logic [ADDR_WIDTH-1:0]                 address,
    input  logic [DATA_WIDTH-1:0]                 write_data,
    output logic                                  ready,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] read_block,
    output logic                                  busy
);

    localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int DEPTH   = 1 << ADDR_WIDTH;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        R_WAIT = 2'd1,
        W_WAIT = 2'd2
    } state_t;

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
    logic [DATA_WIDTH-1:0]                 data_q, data_d;
    logic                                  ready_q, ready_d;
    logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] read_block_q;
    logic                                  mem_we;
    logic                                  blk_ld;

    // Storage is deliberately left out of reset so contents survive a reset
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    // Next-state logic: requests sampled only in IDLE, read wins over write
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;
        blk_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (main_read) begin
                    addr_d  = {address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d   = RD_LOAD;
                    state_d = R_WAIT;
                end else if (main_write) begin
                    addr_d  = address;
                    data_d  = write_data;
                    cnt_d   = WR_LOAD;
                    state_d = W_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    blk_ld  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            W_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers and refill block; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            read_block_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            if (blk_ld) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                    read_block_q[i*DATA_WIDTH +: DATA_WIDTH] <=
                        mem_q[{addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(i)}];
                end
            end
        end
    end

    // Write commit on the same edge that raises ready
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign ready      = ready_q;
    assign read_block = read_block_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - directed self-checking bench for main_mem_responder
module tb_main_mem_responder;

    logic          clk;
    logic          rst_n;
    logic          rd1, wr1, rdy1, busy1;
    logic [9:0]    addr1;
    logic [31:0]   wd1;
    logic [127:0]  blk1;
    logic          rd2, wr2, rdy2, busy2;
    logic [9:0]    addr2;
    logic [31:0]   wd2;
    logic [127:0]  blk2;

    int tests = 0;
    int fails = 0;

    main_mem_responder dut (
        .clk        (clk),
        .reset      (rst_n),
        .main_read  (rd1),
        .main_write (wr1),
        .address    (addr1),
        .write_data (wd1),
        .ready      (rdy1),
        .read_block (blk1),
        .busy       (busy1)
    );

    main_mem_responder #(
        .READ_LATENCY  (1),
        .WRITE_LATENCY (7)
    ) dut2 (
        .clk        (clk),
        .reset      (rst_n),
        .main_read  (rd2),
        .main_write (wr2),
        .address    (addr2),
        .write_data (wd2),
        .ready      (rdy2),
        .read_block (blk2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [9:0] a, input logic [31:0] d);
        if (sel == 1) begin
            rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
        end else begin
            rd2 = rd; wr2 = wr; addr2 = a; wd2 = d;
        end
    endtask

    task automatic sample(input int sel, output logic r, output logic b, output logic [127:0] blk);
        if (sel == 1) begin
            r = rdy1; b = busy1; blk = blk1;
        end else begin
            r = rdy2; b = busy2; blk = blk2;
        end
    endtask

    // Issue one request, hold it until ready, drop it in the ready cycle.
    // d_late replaces write_data one cycle after acceptance.
    task automatic run_op(input int sel, input logic rd, input logic wr, input logic [9:0] a,
                          input logic [31:0] d, input logic [31:0] d_late, input int lat,
                          input string tag);
        logic r, b;
        logic [127:0] blk;
        int first = 0;
        int nr = 0;
        int nb = 0;
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (k == 1) drive(sel, rd, wr, a, d_late);
            sample(sel, r, b, blk);
            if (r) begin
                nr++;
                if (first == 0) first = k;
                drive(sel, 1'b0, 1'b0, a, d_late);
            end
            if (b) nb++;
        end
        drive(sel, 1'b0, 1'b0, a, d_late);
        check({tag, "_ready_at"}, 128'(first), 128'(lat + 1));
        check({tag, "_ready_cnt"}, 128'(nr), 128'd1);
        check({tag, "_busy_cnt"}, 128'(nb), 128'(lat));
    endtask

    task automatic wr_word(input int sel, input logic [9:0] a, input logic [31:0] d, input int lat);
        run_op(sel, 1'b0, 1'b1, a, d, d, lat, "preload");
    endtask

    initial begin
        logic r, b;
        logic [127:0] blk;
        int first, second;

        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(rdy1), 128'd0);
        check("rst_busy", 128'(busy1), 128'd0);
        check("rst_block", blk1, 128'd0);
        check("rst_ready2", 128'(rdy2), 128'd0);
        check("rst_block2", blk2, 128'd0);
        rst_n = 1'b1;

        // Reset mid-write: the pending write must not commit
        wr_word(1, 10'h044, 32'hB0, 4);
        wr_word(1, 10'h045, 32'h0, 4);
        wr_word(1, 10'h046, 32'hB2, 4);
        wr_word(1, 10'h047, 32'hB3, 4);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 10'h045, 32'hDEADBEEF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_ready_in_rst", 128'(rdy1), 128'd0);
        end
        check("midrst_busy", 128'(busy1), 128'd0);
        check("midrst_block", blk1, 128'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_ready_after", 128'(rdy1), 128'd0);
            check("midrst_busy_after", 128'(busy1), 128'd0);
        end
        run_op(1, 1'b1, 1'b0, 10'h044, 32'h0, 32'h0, 4, "midrst_rd");
        blk = blk1;
        check("midrst_word1", 128'(blk[63:32]), 128'd0);
        check("midrst_blk", blk, {32'hB3, 32'hB2, 32'h0, 32'hB0});

        // Basic write then read
        wr_word(1, 10'h3A4, 32'hC0, 4);
        wr_word(1, 10'h3A5, 32'hC1, 4);
        wr_word(1, 10'h3A6, 32'hC2, 4);
        wr_word(1, 10'h3A7, 32'hC3, 4);
        run_op(1, 1'b0, 1'b1, 10'h3A6, 32'h12345678, 32'h12345678, 4, "basic_wr");
        run_op(1, 1'b1, 1'b0, 10'h3A4, 32'h0, 32'h0, 4, "basic_rd");
        blk = blk1;
        check("basic_word2", 128'(blk[95:64]), 128'h12345678);
        check("basic_blk", blk, {32'hC3, 32'h12345678, 32'hC1, 32'hC0});

        // Offset bits ignored on reads
        wr_word(1, 10'h100, 32'hA0, 4);
        wr_word(1, 10'h101, 32'hA1, 4);
        wr_word(1, 10'h102, 32'hA2, 4);
        wr_word(1, 10'h103, 32'hA3, 4);
        run_op(1, 1'b1, 1'b0, 10'h103, 32'h0, 32'h0, 4, "offset_rd");
        check("offset_blk", blk1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Simultaneous read and write: read wins, write dropped
        wr_word(1, 10'h010, 32'h55, 4);
        wr_word(1, 10'h011, 32'h61, 4);
        wr_word(1, 10'h012, 32'h62, 4);
        wr_word(1, 10'h013, 32'h63, 4);
        run_op(1, 1'b1, 1'b1, 10'h010, 32'hFFFF, 32'hFFFF, 4, "simul");
        check("simul_blk", blk1, {32'h63, 32'h62, 32'h61, 32'h55});
        // A write to the same block leaves read_block untouched
        wr_word(1, 10'h011, 32'h77, 4);
        check("wr_keeps_blk", blk1, {32'h63, 32'h62, 32'h61, 32'h55});
        run_op(1, 1'b1, 1'b0, 10'h010, 32'h0, 32'h0, 4, "simul_reread");
        check("simul_reread_blk", blk1, {32'h63, 32'h62, 32'h77, 32'h55});

        // write_data change during wait is ignored
        run_op(1, 1'b0, 1'b1, 10'h020, 32'h11, 32'h22, 4, "late_data");
        run_op(1, 1'b1, 1'b0, 10'h020, 32'h0, 32'h0, 4, "late_rd");
        blk = blk1;
        check("late_data_word0", 128'(blk[31:0]), 128'h11);

        // Read held through its ready cycle starts a second read
        first = 0;
        second = 0;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 10'h100, 32'h0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            sample(1, r, b, blk);
            if (r) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
                if (second != 0) drive(1, 1'b0, 1'b0, 10'h100, 32'h0);
            end
        end
        drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
        check("held_first_ready", 128'(first), 128'd5);
        check("held_second_ready", 128'(second), 128'd10);
        check("held_blk", blk1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Latency sweep on the READ_LATENCY=1 / WRITE_LATENCY=7 instance
        run_op(2, 1'b0, 1'b1, 10'h000, 32'hD0, 32'hD0, 7, "l7_wr0");
        run_op(2, 1'b0, 1'b1, 10'h001, 32'hD1, 32'hD1, 7, "l7_wr1");
        run_op(2, 1'b0, 1'b1, 10'h002, 32'hD2, 32'hD2, 7, "l7_wr2");
        run_op(2, 1'b0, 1'b1, 10'h003, 32'hD3, 32'hD3, 7, "l7_wr3");
        run_op(2, 1'b1, 1'b0, 10'h002, 32'h0, 32'h0, 1, "l1_rd");
        check("l1_blk", blk2, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        check("dut1_blk_unaffected", blk1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
